// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command authorization block.
// Holds the receiver and authorization state encodings and the two command
// bytes the authorization FSM reacts to.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    PWR1 = 2'd1,
    PWR2 = 2'd2
  } auth_state_t;

  localparam logic [7:0] CMD_GO   = 8'h67;  // 'g'
  localparam logic [7:0] CMD_STOP = 8'h73;  // 's'

endpackage

// File: rtl/uart_cmd_auth_if.sv
// Signal bundle between the BLE/load-cell side and the authorization block.
//   RX        : async UART line (8N1, LSB first, idle high)
//   rider_off : load cells report no rider (clk-synchronous)
//   pwr_up    : motors authorized
//   rx_data   : last accepted byte
//   rx_rdy    : one-cycle pulse, new rx_data
//   frm_err   : one-cycle pulse, byte rejected for bad stop bit
// master drives RX/rider_off; slave (the block) drives the rest.
interface uart_cmd_auth_if;
  logic       RX;
  logic       rider_off;
  logic       pwr_up;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       frm_err;

  modport master (output RX, rider_off, input pwr_up, rx_data, rx_rdy, frm_err);
  modport slave  (input RX, rider_off, output pwr_up, rx_data, rx_rdy, frm_err);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: RX synchronizer + edge detect, IDLE/START/DATA/STOP
// FSM, baud and bit counters.
//   clk, rst_n : clock, synchronous active-low reset
//   rx         : async serial line
//   rx_data    : last accepted byte
//   rx_rdy     : one-cycle pulse per accepted byte
//   frm_err    : one-cycle pulse per byte rejected for a low stop bit
// Macro FRAMING_CHK_EN enables stop-bit checking; without it the stop bit is
// ignored and frm_err is constant 0.
module uart_rx_byte
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frm_err
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

  logic            s1, s2, s3;
  logic            fall;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt;
  logic [3:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            cnt_clr, bit_clr, shift_en, stop_done;

  // s1/s2 synchronize; s3 is the delayed copy for falling-edge detect.
  always_ff @(posedge clk) begin
    if (!rst_n) {s1, s2, s3} <= 3'b111;
    else begin
      s1 <= rx;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fall = s3 & ~s2;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    bit_clr   = 1'b0;
    shift_en  = 1'b0;
    stop_done = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (fall) state_d = START;
      end
      START: if (cnt == HALF_M1) begin
        cnt_clr = 1'b1;
        bit_clr = 1'b1;
        state_d = s2 ? IDLE : DATA;  // high at mid-start = glitch
      end
      DATA: if (cnt == FULL_M1) begin
        cnt_clr  = 1'b1;
        shift_en = 1'b1;
        if (bit_cnt == 4'd7) state_d = STOP;
      end
      STOP: if (cnt == FULL_M1) begin
        cnt_clr   = 1'b1;
        stop_done = 1'b1;
        // an edge arriving as we return to idle starts the next frame
        state_d   = fall ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      rx_data <= '0;
      rx_rdy  <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      rx_rdy  <= 1'b0;
      frm_err <= 1'b0;
      cnt     <= cnt_clr ? '0 : cnt + 1'b1;
      if (bit_clr) bit_cnt <= '0;
      if (shift_en) begin
        shreg   <= {s2, shreg[7:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (stop_done) begin
`ifdef FRAMING_CHK_EN
        if (s2) begin
          rx_data <= shreg;
          rx_rdy  <= 1'b1;
        end else begin
          frm_err <= 1'b1;
        end
`else
        rx_data <= shreg;
        rx_rdy  <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: rtl/uart_cmd_auth.sv
// Segway power authorization over a BLE UART link. A 'g' byte arms the
// motors, 's' disarms once the rider has stepped off (or waits in PWR2 for
// rider_off if a rider is still on).
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : uart_cmd_auth_if.slave (RX, rider_off in; pwr_up, rx_data,
//                rx_rdy, frm_err out)
// Macro FRAMING_CHK_EN (passed to uart_rx_byte) rejects bytes with a low stop bit.
module uart_cmd_auth
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_cmd_auth_if.slave  bus
);

  logic [7:0]  rx_data;
  logic        rx_rdy, frm_err;
  auth_state_t state_q, state_d;

  uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (bus.RX),
    .rx_data (rx_data),
    .rx_rdy  (rx_rdy),
    .frm_err (frm_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= OFF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF:  if (rx_rdy && rx_data == CMD_GO) state_d = PWR1;
      PWR1: if (rx_rdy && rx_data == CMD_STOP) state_d = bus.rider_off ? OFF : PWR2;
      // 'g' wins over a simultaneous rider_off
      PWR2: if (rx_rdy && rx_data == CMD_GO) state_d = PWR1;
            else if (bus.rider_off)          state_d = OFF;
      default: state_d = OFF;
    endcase
  end

  assign bus.pwr_up  = (state_q != OFF);
  assign bus.rx_data = rx_data;
  assign bus.rx_rdy  = rx_rdy;
  assign bus.frm_err = frm_err;

endmodule

// File: tb/tb_uart_cmd_auth.sv
module tb_uart_cmd_auth;
  import uart_cmd_pkg::*;

  localparam int BD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   rdy_cnt = 0;
  int   frm_cnt = 0;

  uart_cmd_auth_if u_if ();

  uart_cmd_auth #(.BAUD_DIV(BD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (u_if.rx_rdy)  rdy_cnt++;
    if (u_if.frm_err) frm_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    u_if.RX = v;
    idle(BD);
  endtask

  // Start + 8 data bits; leaves RX at the stop level at the stop-bit start.
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    u_if.RX = stop_lvl;
  endtask

  task automatic wait_evt(output logic got);
    got = 1'b0;
    for (int i = 0; i < 3 * BD && !got; i++) begin
      @(negedge clk);
      if (u_if.rx_rdy || u_if.frm_err) got = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Send a byte and check that rx_rdy appears with the given data and the
  // resulting pwr_up one cycle later.
  task automatic send_expect(input string name, input logic [7:0] b, input logic exp_pwr);
    logic got;
    send_frame(b, 1'b1);
    wait_evt(got);
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL %s_rdy: got no rx_rdy, required pulse", name); end
    checks++;
    if (u_if.rx_data !== b) begin errors++; $display("FAIL %s_data: got %h, required %h", name, u_if.rx_data, b); end
    @(negedge clk);
    checks++;
    if (u_if.pwr_up !== exp_pwr) begin errors++; $display("FAIL %s_pwr: got %b, required %b", name, u_if.pwr_up, exp_pwr); end
    idle(BD);
  endtask

  task automatic test_reset;
    u_if.RX = 1'b1;
    u_if.rider_off = 1'b1;
    rst_n = 1'b0;
    idle(3);
    checks++; if (u_if.pwr_up  !== 1'b0)  begin errors++; $display("FAIL rst_pwr: got %b, required 0", u_if.pwr_up); end
    checks++; if (u_if.rx_rdy  !== 1'b0)  begin errors++; $display("FAIL rst_rdy: got %b, required 0", u_if.rx_rdy); end
    checks++; if (u_if.rx_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h, required 00", u_if.rx_data); end
    checks++; if (u_if.frm_err !== 1'b0)  begin errors++; $display("FAIL rst_frm: got %b, required 0", u_if.frm_err); end
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_go;
    logic got;
    int r0;
    r0 = rdy_cnt;
    u_if.rider_off = 1'b1;
    send_frame(CMD_GO, 1'b1);
    wait_evt(got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL go_rdy: got no pulse, required pulse"); end
    checks++; if (u_if.rx_data !== 8'h67) begin errors++; $display("FAIL go_data: got %h, required 67", u_if.rx_data); end
    checks++; if (u_if.pwr_up !== 1'b0) begin errors++; $display("FAIL go_pwr_early: got %b, required 0", u_if.pwr_up); end
    @(negedge clk);
    checks++; if (u_if.pwr_up !== 1'b1) begin errors++; $display("FAIL go_pwr: got %b, required 1", u_if.pwr_up); end
    checks++; if (u_if.rx_rdy !== 1'b0) begin errors++; $display("FAIL go_rdy_width: got %b, required 0", u_if.rx_rdy); end
    idle(BD);
    checks++; if (rdy_cnt - r0 !== 1) begin errors++; $display("FAIL go_rdy_count: got %0d, required 1", rdy_cnt - r0); end
  endtask

  task automatic test_pwr2_rider_off;
    u_if.rider_off = 1'b0;
    send_expect("stop_pwr2", CMD_STOP, 1'b1);
    idle(5);
    checks++; if (u_if.pwr_up !== 1'b1) begin errors++; $display("FAIL pwr2_hold: got %b, required 1", u_if.pwr_up); end
    u_if.rider_off = 1'b1;
    @(negedge clk);
    checks++; if (u_if.pwr_up !== 1'b0) begin errors++; $display("FAIL pwr2_rider_off: got %b, required 0", u_if.pwr_up); end
  endtask

  task automatic test_go_priority;
    logic got;
    // rebuild PWR2: 'g' then 's' with a rider on
    u_if.rider_off = 1'b1;
    send_expect("prio_go", CMD_GO, 1'b1);
    u_if.rider_off = 1'b0;
    send_expect("prio_stop", CMD_STOP, 1'b1);
    send_frame(CMD_GO, 1'b1);
    wait_evt(got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL prio_rdy: got no pulse, required pulse"); end
    u_if.rider_off = 1'b1;  // rises in the rx_rdy cycle
    @(negedge clk);
    checks++; if (u_if.pwr_up !== 1'b1) begin errors++; $display("FAIL prio_pwr: got %b, required 1", u_if.pwr_up); end
    idle(5);
    // PWR1 ignores rider_off; PWR2 would have dropped
    checks++; if (u_if.pwr_up !== 1'b1) begin errors++; $display("FAIL prio_in_pwr1: got %b, required 1", u_if.pwr_up); end
    idle(BD);
  endtask

  task automatic test_glitch;
    int r0, f0;
    r0 = rdy_cnt;
    f0 = frm_cnt;
    u_if.RX = 1'b0;
    idle(BD * 3 / 10);
    u_if.RX = 1'b1;
    idle(12 * BD);
    checks++; if (rdy_cnt - r0 !== 0) begin errors++; $display("FAIL glitch_rdy: got %0d, required 0", rdy_cnt - r0); end
    checks++; if (frm_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_frm: got %0d, required 0", frm_cnt - f0); end
    send_expect("glitch_a5", 8'hA5, 1'b1);
  endtask

  task automatic test_back_to_back;
    int r0;
    logic got;
    r0 = rdy_cnt;
    u_if.rider_off = 1'b1;
    send_frame(CMD_GO, 1'b1);
    idle(BD);
    send_frame(CMD_STOP, 1'b1);
    wait_evt(got);
    idle(BD);
    checks++; if (rdy_cnt - r0 !== 2) begin errors++; $display("FAIL b2b_count: got %0d, required 2", rdy_cnt - r0); end
    checks++; if (u_if.rx_data !== 8'h73) begin errors++; $display("FAIL b2b_data: got %h, required 73", u_if.rx_data); end
    checks++; if (u_if.pwr_up !== 1'b0) begin errors++; $display("FAIL b2b_pwr: got %b, required 0", u_if.pwr_up); end
  endtask

  task automatic test_framing;
    logic got;
    int r0, f0;
    r0 = rdy_cnt;
    f0 = frm_cnt;
    send_frame(CMD_GO, 1'b0);
    wait_evt(got);
    u_if.RX = 1'b1;
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL frm_event: got none, required pulse"); end
    @(negedge clk);
    idle(BD);
`ifdef FRAMING_CHK_EN
    checks++; if (frm_cnt - f0 !== 1) begin errors++; $display("FAIL frm_err_count: got %0d, required 1", frm_cnt - f0); end
    checks++; if (rdy_cnt - r0 !== 0) begin errors++; $display("FAIL frm_rdy_count: got %0d, required 0", rdy_cnt - r0); end
    checks++; if (u_if.rx_data !== 8'h73) begin errors++; $display("FAIL frm_data: got %h, required 73", u_if.rx_data); end
    checks++; if (u_if.pwr_up !== 1'b0) begin errors++; $display("FAIL frm_pwr: got %b, required 0", u_if.pwr_up); end
    send_expect("frm_regain", CMD_GO, 1'b1);
`else
    checks++; if (frm_cnt - f0 !== 0) begin errors++; $display("FAIL frm_err_count: got %0d, required 0", frm_cnt - f0); end
    checks++; if (rdy_cnt - r0 !== 1) begin errors++; $display("FAIL frm_rdy_count: got %0d, required 1", rdy_cnt - r0); end
    checks++; if (u_if.rx_data !== 8'h67) begin errors++; $display("FAIL frm_data: got %h, required 67", u_if.rx_data); end
    checks++; if (u_if.pwr_up !== 1'b1) begin errors++; $display("FAIL frm_pwr: got %b, required 1", u_if.pwr_up); end
`endif
  endtask

  task automatic test_reset_midframe;
    int r0;
    logic [7:0] b;
    b = CMD_GO;
    checks++; if (u_if.pwr_up !== 1'b1) begin errors++; $display("FAIL mid_pre_pwr: got %b, required 1", u_if.pwr_up); end
    r0 = rdy_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    u_if.RX = b[4];
    idle(BD / 2);
    rst_n = 1'b0;
    u_if.RX = 1'b1;  // the sender abandons the frame too
    idle(3);
    checks++; if (u_if.pwr_up !== 1'b0) begin errors++; $display("FAIL mid_rst_pwr: got %b, required 0", u_if.pwr_up); end
    rst_n = 1'b1;
    idle(12 * BD);
    checks++; if (rdy_cnt - r0 !== 0) begin errors++; $display("FAIL mid_rst_rdy: got %0d, required 0", rdy_cnt - r0); end
    checks++; if (u_if.pwr_up !== 1'b0) begin errors++; $display("FAIL mid_rst_pwr_after: got %b, required 0", u_if.pwr_up); end
    send_expect("mid_fresh_go", CMD_GO, 1'b1);
  endtask

  initial begin
    u_if.RX = 1'b1;
    u_if.rider_off = 1'b1;
    @(negedge clk);
    test_reset();
    test_go();
    test_pwr2_rider_off();
    test_go_priority();
    test_glitch();
    test_back_to_back();
    test_framing();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
